// File: rtl/alu_pkg.sv
// Shared definitions for the conditional add/subtract unit.
package alu_pkg;

  localparam logic SEL_SUB = 1'b0;
  localparam logic SEL_ADD = 1'b1;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Flags consistent with a cleared result of zero.
  localparam flags_t FLAGS_RST = '{carry: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract with carry-or-borrow and signed overflow.
module addsub_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  logic             is_add;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;

  always_comb begin
    is_add  = (sel == SEL_ADD);
    // Subtraction is a + ~b + 1; the borrow is the inverted carry-out.
    b_op    = is_add ? b : ~b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, ~is_add};
    res     = sum_ext[WIDTH-1:0];
    carry   = is_add ? sum_ext[WIDTH] : ~sum_ext[WIDTH];
    // Same-sign test on b_op covers both ops: for subtract it means a and b differ in sign.
    ovf     = (a[WIDTH-1] == b_op[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_conditional.sv
// Registered conditional add/subtract with status flags, one cycle of latency.
module alu_conditional
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;

  logic [WIDTH-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (a),
    .b    (b),
    .sel  (sel),
    .res  (core_res),
    .carry(core_carry),
    .ovf  (core_ovf)
  );

  always_comb begin
    y_d         = y_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d           = core_res;
      flags_d.carry = core_carry;
      flags_d.ovf   = core_ovf;
      flags_d.zero  = (core_res == '0);
      flags_d.neg   = core_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      flags_q     <= FLAGS_RST;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_conditional.sv
// Scoreboard bench for alu_conditional at WIDTH=4.
module tb_alu_conditional;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] y;
  logic         carry, ovf, zero, neg, out_valid;

  exp_t q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_conditional #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .in_valid (in_valid),
    .y        (y),
    .carry    (carry),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .out_valid(out_valid)
  );

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input int av, input int bv, input logic s);
    exp_t e;
    int m, h, sa, sb, r, sr;
    m  = 1 << W;
    h  = 1 << (W - 1);
    sa = (av >= h) ? av - m : av;
    sb = (bv >= h) ? bv - m : bv;
    if (s) begin
      r       = av + bv;
      sr      = sa + sb;
      e.carry = (r >= m);
    end else begin
      r       = av - bv;
      sr      = sa - sb;
      e.carry = (av < bv);
    end
    e.y    = W'(((r % m) + m) % m);
    e.ovf  = (sr < -h) || (sr > h - 1);
    e.zero = (e.y == '0);
    e.neg  = e.y[W-1];
    return e;
  endfunction

  // Called at posedge+1; drives one cycle of stimulus, then checks the registered outputs.
  task automatic step(input string name, input int av, input int bv, input logic s,
                      input logic v);
    exp_t e;
    logic ev;
    a        = W'(av);
    b        = W'(bv);
    sel      = s;
    in_valid = v;
    if (v) q.push_back(model(av, bv, s));
    @(posedge clk);
    #1;
    if (v) begin
      e        = q.pop_front();
      last_exp = e;
      ev       = 1'b1;
    end else begin
      e  = last_exp;
      ev = 1'b0;
    end
    checks++;
    if ({y, carry, ovf, zero, neg, out_valid} !== {e, ev}) begin
      errors++;
      $display("FAIL %s: got y=%0d c=%b o=%b z=%b n=%b v=%b, want y=%0d c=%b o=%b z=%b n=%b v=%b",
               name, y, carry, ovf, zero, neg, out_valid,
               e.y, e.carry, e.ovf, e.zero, e.neg, ev);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({y, carry, ovf, zero, neg, out_valid} !== {W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got y=%0d c=%b o=%b z=%b n=%b v=%b, want y=0 c=0 o=0 z=1 n=0 v=0",
               name, y, carry, ovf, zero, neg, out_valid);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1 check_reset_vals("reset_async");
    @(posedge clk);
    #1 check_reset_vals("reset_held");
    rst      = 1'b0;
    last_exp = '{y: '0, carry: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
  endtask

  task automatic test_basic();
    step("add_4_2", 4, 2, 1'b1, 1'b1);
    step("sub_4_2", 4, 2, 1'b0, 1'b1);
    step("add_7_5", 7, 5, 1'b1, 1'b1);
    step("sub_7_5", 7, 5, 1'b0, 1'b1);
    // Spot-check against hand-derived values, independent of the model.
    checks++;
    if ({y, carry, ovf, zero, neg} !== {W'(2), 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_7_5_const: got y=%0d c=%b o=%b z=%b n=%b, want y=2 flags 0",
               y, carry, ovf, zero, neg);
    end
  endtask

  task automatic test_wrap();
    step("add_9_9", 9, 9, 1'b1, 1'b1);
    step("sub_2_4", 2, 4, 1'b0, 1'b1);
    checks++;
    if ({y, carry, neg} !== {W'(14), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_2_4_const: got y=%0d c=%b n=%b, want y=14 c=1 n=1", y, carry, neg);
    end
    step("sub_5_5", 5, 5, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    step("add_7_1", 7, 1, 1'b1, 1'b1);
    checks++;
    if ({y, ovf} !== {W'(8), 1'b1}) begin
      errors++;
      $display("FAIL add_7_1_const: got y=%0d o=%b, want y=8 o=1", y, ovf);
    end
    step("sub_8_1", 8, 1, 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    step("hold_seed", 3, 6, 1'b1, 1'b1);
    step("hold_1", 15, 15, 1'b0, 1'b0);
    step("hold_2", 1, 9, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    step("b2b_0", 1, 2, 1'b1, 1'b1);
    step("b2b_1", 12, 3, 1'b0, 1'b1);
    step("b2b_2", 8, 8, 1'b1, 1'b1);
    step("b2b_3", 0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      step("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic test_mid_reset();
    step("pre_reset", 6, 3, 1'b1, 1'b1);
    a        = W'(5);
    b        = W'(4);
    sel      = 1'b1;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_reset_async");
    @(posedge clk);
    #1 check_reset_vals("mid_reset_edge");
    rst      = 1'b0;
    last_exp = '{y: '0, carry: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
    step("post_reset_idle", 5, 4, 1'b1, 1'b0);
    step("post_reset_op", 5, 4, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, want finish before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_conditional.md
# alu_conditional

Registered two-operation arithmetic unit: adds or subtracts two unsigned WIDTH-bit operands under a single select bit. It drives a registered result with status flags one clock after the operands are accepted. It is a leaf datapath block used wherever a simple conditional add/subtract with flags is needed. All state is cleared by an asynchronous reset.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-high
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- sel  input  1  operation select: 1 = a + b, 0 = a - b
- in_valid  input  1  operands and sel are sampled only when high
- y  output  WIDTH  registered result, modulo 2^WIDTH
- carry  output  1  add: carry-out; subtract: borrow (1 when a < b unsigned)
- ovf  output  1  two's-complement signed overflow of the selected operation
- zero  output  1  1 when y == 0
- neg  output  1  copy of y[WIDTH-1]
- out_valid  output  1  high for the cycle(s) in which y and the flags hold a freshly computed result

## Operation
- Add: {carry, y} = a + b, computed at WIDTH+1 bits.
- Subtract: y = (a - b) mod 2^WIDTH.
  - carry = 1 when a < b (borrow).
  - Implement as a + ~b + 1. The borrow is the inverted carry-out of that sum.
- ovf, add: operands have the same sign and the result sign differs.
- ovf, subtract: operand signs differ and the result sign differs from a.
- zero and neg are derived from the result being registered, not from the previous y.
- When in_valid = 0:
  - y, carry, ovf, zero and neg hold their previous values.
  - out_valid goes low at the next edge.
- sel is sampled together with a and b. A change of sel without in_valid has no effect.
- There is no backpressure. A result is overwritten by the next accepted operand set.

## Timing
- Latency is 1 cycle. Operands accepted at edge N appear on y and the flags after edge N, with out_valid = 1 in the cycle that follows.
- Throughput is one operation per clock when in_valid is held high.
- Reset (asynchronous assert):
  - y = 0, carry = 0, ovf = 0, out_valid = 0 immediately.
  - zero = 1, consistent with y = 0. neg = 0.
- Reset release: the first edge with rst = 0 and in_valid = 1 accepts operands normally.
- Reset asserted mid-stream: the in-flight result is discarded and outputs take their reset values at once.
- No combinational path from any input to any output.

## Structure
- Shared package alu_pkg:
  - constants SEL_SUB = 1'b0 and SEL_ADD = 1'b1
  - a typedef for the flag bundle {carry, ovf, zero, neg}
- One natural sub-module, addsub_core:
  - purely combinational
  - WIDTH-parameterized
  - produces the sum/difference, carry/borrow and ovf
- The top level holds the input-sample and output registers, the zero/neg derivation and the valid tracking.

## Test plan
- Reset: assert rst mid-cycle -> immediately y=0, zero=1, carry=0, ovf=0, out_valid=0.
- Basic ops with WIDTH=4, in_valid=1:
  - a=4, b=2, sel=1 -> next cycle y=6.
  - a=4, b=2, sel=0 -> y=2.
  - a=7, b=5, sel=1 -> y=12, ovf=1, neg=1.
  - a=7, b=5, sel=0 -> y=2, all flags 0.
- Wrap/borrow:
  - a=9, b=9, sel=1 -> y=2, carry=1.
  - a=2, b=4, sel=0 -> y=14, carry=1, neg=1.
  - a=5, b=5, sel=0 -> y=0, zero=1, carry=0.
- Signed overflow:
  - a=7, b=1, sel=1 -> y=8, ovf=1.
  - a=8, b=1, sel=0 -> y=7, ovf=1.
- Hold: after a valid result, drive in_valid=0 with new a/b/sel -> y and flags unchanged, out_valid drops after one edge.
- Back-to-back: four consecutive valid operand sets -> four results on consecutive cycles, each one cycle after its inputs.
